// File: rtl/fifo.sv
// Single-clock 16x8 FIFO with full/empty flags and an overflow/underflow error flag.
// Define FIFO_STICKY_ERROR_EN to make error_o stick until reset.
module fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  error_o
);

  localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  rej;
  logic                  err_q;

  assign empty_o = (wr_ptr == rd_ptr);
  assign full_o  = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0])
                 & (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);

  // A read frees a slot in the same cycle, so a full FIFO can still take a write.
  assign rd_ok = rd_en_i & ~empty_o;
  assign wr_ok = wr_en_i & (~full_o | rd_ok);
  assign rej   = (wr_en_i & ~wr_ok) | (rd_en_i & ~rd_ok);

  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
    end else if (wr_ok) begin
      wr_ptr <= wr_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_ptr  <= '0;
      rdata_o <= '0;
    end else if (rd_ok) begin
      rd_ptr  <= rd_ptr + PTR_ONE;
      rdata_o <= mem[rd_ptr[ADDR_WIDTH-1:0]];
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      err_q <= 1'b0;
    end else begin
`ifdef FIFO_STICKY_ERROR_EN
      err_q <= err_q | rej;
`else
      err_q <= rej;
`endif
    end
  end

  assign error_o = err_q;

endmodule

// File: tb/tb_fifo.sv
// Bench for fifo: directed steps plus random traffic against a queue model.
// Expected values come from the queue model evaluated per clock.
module tb_fifo;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       wr_en_i;
  logic [7:0] wdata_i;
  logic       rd_en_i;
  logic [7:0] rdata_o;
  logic       full_o;
  logic       empty_o;
  logic       error_o;

  int total = 0;
  int bad   = 0;

  logic [7:0] q[$];
  logic [7:0] m_rdata;
  logic       m_err;

  always #5 clk_i = ~clk_i;

  fifo dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .wr_en_i (wr_en_i),
    .wdata_i (wdata_i),
    .rd_en_i (rd_en_i),
    .rdata_o (rdata_o),
    .full_o  (full_o),
    .empty_o (empty_o),
    .error_o (error_o)
  );

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rdata"}, rdata_o, m_rdata);
    chk({tag, ".full"},  {7'd0, full_o},  {7'd0, q.size() == 16});
    chk({tag, ".empty"}, {7'd0, empty_o}, {7'd0, q.size() == 0});
    chk({tag, ".error"}, {7'd0, error_o}, {7'd0, m_err});
  endtask

  task automatic model_reset();
    q.delete();
    m_rdata = 8'h00;
    m_err   = 1'b0;
  endtask

  // One clock: drive at negedge, update model at posedge, check 1ns later.
  task automatic step(input logic wr, input logic [7:0] wd,
                      input logic rd, input string tag);
    logic rd_ok, wr_ok, rej;
    @(negedge clk_i);
    wr_en_i = wr;
    wdata_i = wd;
    rd_en_i = rd;
    @(posedge clk_i);
    rd_ok = rd && (q.size() > 0);
    wr_ok = wr && ((q.size() < 16) || rd_ok);
    rej   = (wr && !wr_ok) || (rd && !rd_ok);
    if (rd_ok) m_rdata = q.pop_front();
    if (wr_ok) q.push_back(wd);
`ifdef FIFO_STICKY_ERROR_EN
    m_err = m_err | rej;
`else
    m_err = rej;
`endif
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk_i);
    wr_en_i = 1'b0;
    rd_en_i = 1'b0;
    #2;
    rst_i = 1'b0;
    #1;
    model_reset();
    check_all({tag, ".async"});
    repeat (2) @(posedge clk_i);
    #1;
    check_all(tag);
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  initial begin
    rst_i   = 1'b0;
    wr_en_i = 1'b0;
    wdata_i = 8'h00;
    rd_en_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check_all("reset");
    @(negedge clk_i);
    rst_i = 1'b1;

    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0, "fill");
    for (int i = 1; i <= 16; i++) step(1'b0, 8'h00, 1'b1, "drain");

    for (int i = 1; i <= 17; i++) step(1'b1, 8'(8'h20 + i), 1'b0, "ovf_wr");
    step(1'b0, 8'h00, 1'b0, "ovf_idle");
    for (int i = 1; i <= 16; i++) step(1'b0, 8'h00, 1'b1, "ovf_rd");

    for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0, "udf_fill");
    for (int i = 1; i <= 17; i++) step(1'b0, 8'h00, 1'b1, "udf_rd");
    step(1'b0, 8'h00, 1'b0, "udf_idle");

    do_reset("rst1");

    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h40 + i), 1'b0, "wrap_wr");
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b1, "wrap_rd");
    for (int i = 0; i < 12; i++) step(1'b1, 8'(8'h60 + i), 1'b1, "wrap_wrrd");
    step(1'b0, 8'h00, 1'b1, "wrap_last");

    step(1'b1, 8'hA5, 1'b1, "empty_wrrd");
    step(1'b0, 8'h00, 1'b1, "empty_rdback");

    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h80 + i), 1'b0, "full_fill");
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 1'b1, "full_wrrd");

    do_reset("rst2");

    for (int i = 0; i < 600; i++) begin
      logic wr, rd;
      wr = ($urandom_range(0, 99) < 55);
      rd = ($urandom_range(0, 99) < 45);
      step(wr, 8'($urandom), rd, "rand");
    end

    do_reset("rst3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
